// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, FSM states and Booth-pair decode for booth_mul_16bit
package mul_pkg;
  localparam int MUL_WIDTH = 16;
  localparam int MUL_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/booth_mul_16bit_if.sv
// booth_mul_16bit_if: start/busy/done handshake bundle; Ovf present when BOOTH_OVF_FLAG_EN is defined
interface booth_mul_16bit_if;
  import mul_pkg::*;
  logic Start;
  logic [MUL_WIDTH-1:0] A;
  logic [MUL_WIDTH-1:0] B;
  logic Busy;
  logic Done;
  logic [2*MUL_WIDTH-1:0] Product;
`ifdef BOOTH_OVF_FLAG_EN
  logic Ovf;
  modport master(output Start, A, B, input Busy, Done, Product, Ovf);
  modport slave(input Start, A, B, output Busy, Done, Product, Ovf);
`else
  modport master(output Start, A, B, input Busy, Done, Product);
  modport slave(input Start, A, B, output Busy, Done, Product);
`endif
endinterface

// File: rtl/add_sub_16bit.sv
// add_sub_16bit: 16-bit adder/subtractor, Sum = A + B or A - B
module add_sub_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  output logic [15:0] Sum,
  output logic        Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B ^ {16{Sub}}} + {16'b0, Sub};
endmodule

// File: rtl/booth_mul_16bit.sv
// booth_mul_16bit: iterative radix-2 Booth signed multiplier; BOOTH_OVF_FLAG_EN adds the Ovf flag
module booth_mul_16bit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic clk,
  input logic rst,
  booth_mul_16bit_if.slave bus
);
  mul_state_t state, state_n;
  logic [WIDTH-1:0] m, q, acc, sum, acc_n, q_n;
  logic [2*WIDTH-1:0] product;
  logic [MUL_CNT_W-1:0] cnt;
  logic q_m1, sub, add_en, ovf, last;
  logic [1:0] pair;
  logic [WIDTH:0] acc_x;
  add_sub_16bit u_add_sub (.A(acc), .B(m), .Sub(sub), .Sum(sum), .Cout());
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.Start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  // 17-bit true sign of the adder result keeps M=0x8000 exact through the shift
  always_comb begin
    pair   = {q[0], q_m1};
    sub    = pair == BOOTH_SUB;
    add_en = pair == BOOTH_SUB || pair == BOOTH_ADD;
    last   = cnt == '1;
    ovf    = (sub ? m[WIDTH-1] != acc[WIDTH-1] : m[WIDTH-1] == acc[WIDTH-1]) && sum[WIDTH-1] != acc[WIDTH-1];
    acc_x  = add_en ? {sum[WIDTH-1] ^ ovf, sum} : {acc[WIDTH-1], acc};
    acc_n  = acc_x[WIDTH:1];
    q_n    = {acc_x[0], q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (state == IDLE && bus.Start) begin
      m    <= bus.A;
      q    <= bus.B;
      acc  <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc  <= acc_n;
      q    <= q_n;
      q_m1 <= q[0];
      cnt  <= cnt + 1'b1;
      if (last) product <= {acc_n, q_n};
    end
  assign bus.Busy    = state != IDLE;
  assign bus.Done    = state == DONE;
  assign bus.Product = product;
`ifdef BOOTH_OVF_FLAG_EN
  logic ovf_r;
  logic [WIDTH:0] top_n;
  assign top_n = {acc_n, q_n[WIDTH-1]};
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_r <= 1'b0;
    else if (state == RUN && last) ovf_r <= !(&top_n || !(|top_n));
  assign bus.Ovf = ovf_r;
`endif
endmodule

// File: tb/tb_booth_mul_16bit.sv
// tb_booth_mul_16bit: directed vectors for booth_mul_16bit (define BOOTH_OVF_FLAG_EN to also check Ovf)
module tb_booth_mul_16bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  booth_mul_16bit_if bus();
  booth_mul_16bit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
    bus.Start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask
  // waits for Done counting edges after the Start edge, then checks the drop after E17
  task automatic wait_done(input string tag, input int n0, input logic [31:0] exp);
    int n;
    int busy_ok;
    n = n0;
    busy_ok = 1;
    while (!bus.Done && n < 40) begin
      if (!bus.Busy) busy_ok = 0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'd16);
    check({tag, "_prod"}, bus.Product, exp);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, {31'b0, bus.Done}, 32'd0);
    check({tag, "_busy_drop"}, {31'b0, bus.Busy}, 32'd0);
    check({tag, "_hold"}, bus.Product, exp);
  endtask
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    pulse_start(a, b);
    check({tag, "_busy_rise"}, {31'b0, bus.Busy}, 32'd1);
    wait_done(tag, 0, exp);
  endtask
  initial begin
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #1;
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_done", {31'b0, bus.Done}, 32'd0);
    check("rst_prod", bus.Product, 32'd0);
`ifdef BOOTH_OVF_FLAG_EN
    check("rst_ovf", {31'b0, bus.Ovf}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run("m3x5", 16'h0003, 16'h0005, 32'h0000000F);
    run("mneg1", 16'hFFFF, 16'hFFFF, 32'h00000001);
    run("mmin", 16'h8000, 16'h8000, 32'h40000000);
`ifdef BOOTH_OVF_FLAG_EN
    check("mmin_ovf", {31'b0, bus.Ovf}, 32'd1);
`endif
    run("mmax_min", 16'h7FFF, 16'h8000, 32'hC0008000);
    run("mzero", 16'h0000, 16'h1234, 32'h00000000);
`ifdef BOOTH_OVF_FLAG_EN
    check("mzero_ovf", {31'b0, bus.Ovf}, 32'd0);
`endif
    pulse_start(16'd2, 16'd3);
    repeat (4) begin
      @(posedge clk); #1;
    end
    pulse_start(16'd9, 16'd9);
    wait_done("ign", 5, 32'h00000006);
    pulse_start(16'd3, 16'd3);
    check("e18_accept", {31'b0, bus.Busy}, 32'd1);
    wait_done("e18", 0, 32'h00000009);
    pulse_start(16'h0100, 16'h0100);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("mid_rst_done", {31'b0, bus.Done}, 32'd0);
    check("mid_rst_prod", bus.Product, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run("m2xm3", 16'h0002, 16'hFFFD, 32'hFFFFFFFA);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
